// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: bus widths, ALU operation and
// result-class codes, divider state encodings and a small sign helper.
package ex_pkg;

   localparam int ALU_OP_BUS   = 8;
   localparam int ALU_SEL_BUS  = 3;
   localparam int REG_BUS      = 32;
   localparam int REG_ADDR_BUS = 5;

   localparam logic                ENABLE  = 1'b1;
   localparam logic                DISABLE = 1'b0;
   localparam logic [REG_BUS-1:0]  ZERO_32 = '0;

   typedef enum logic [ALU_SEL_BUS-1:0] {
      SEL_NOP   = 3'd0,
      SEL_LOGIC = 3'd1,
      SEL_SHIFT = 3'd2,
      SEL_ARITH = 3'd3,
      SEL_MUL   = 3'd4,
      SEL_DIV   = 3'd5
   } alu_sel_e;

   localparam logic [ALU_OP_BUS-1:0] OP_NOP    = 8'h00;
   localparam logic [ALU_OP_BUS-1:0] OP_AND    = 8'h01;
   localparam logic [ALU_OP_BUS-1:0] OP_OR     = 8'h02;
   localparam logic [ALU_OP_BUS-1:0] OP_XOR    = 8'h03;
   localparam logic [ALU_OP_BUS-1:0] OP_SLL    = 8'h10;
   localparam logic [ALU_OP_BUS-1:0] OP_SRL    = 8'h11;
   localparam logic [ALU_OP_BUS-1:0] OP_SRA    = 8'h12;
   localparam logic [ALU_OP_BUS-1:0] OP_ADD    = 8'h20;
   localparam logic [ALU_OP_BUS-1:0] OP_SUB    = 8'h21;
   localparam logic [ALU_OP_BUS-1:0] OP_SLT    = 8'h22;
   localparam logic [ALU_OP_BUS-1:0] OP_SLTU   = 8'h23;
   localparam logic [ALU_OP_BUS-1:0] OP_LUI    = 8'h24;
   localparam logic [ALU_OP_BUS-1:0] OP_AUIPC  = 8'h25;
   localparam logic [ALU_OP_BUS-1:0] OP_JAL    = 8'h26;
   localparam logic [ALU_OP_BUS-1:0] OP_MUL    = 8'h30;
   localparam logic [ALU_OP_BUS-1:0] OP_MULH   = 8'h31;
   localparam logic [ALU_OP_BUS-1:0] OP_MULHSU = 8'h32;
   localparam logic [ALU_OP_BUS-1:0] OP_MULHU  = 8'h33;
   localparam logic [ALU_OP_BUS-1:0] OP_DIV    = 8'h40;
   localparam logic [ALU_OP_BUS-1:0] OP_DIVU   = 8'h41;
   localparam logic [ALU_OP_BUS-1:0] OP_REM    = 8'h42;
   localparam logic [ALU_OP_BUS-1:0] OP_REMU   = 8'h43;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   function automatic logic [REG_BUS-1:0] neg_if(input logic [REG_BUS-1:0] v, input logic n);
      return n ? (ZERO_32 - v) : v;
   endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative 32-step restoring divider with signed/unsigned support; result
// held in DONE for one cycle, flush aborts from any state.
module ex_div
   import ex_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_op,
   input  logic [REG_BUS-1:0] dividend,
   input  logic [REG_BUS-1:0] divisor,
   input  logic               flush,
   output logic               busy,
   output logic               done,
   output logic [REG_BUS-1:0] quotient,
   output logic [REG_BUS-1:0] remainder
);

   div_state_e         state_q, state_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [63:0]        rq_q, rq_d;
   logic [REG_BUS-1:0] dsor_q, dsor_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic [REG_BUS-1:0] quo_q, quo_d;
   logic [REG_BUS-1:0] rem_q, rem_d;

   logic [32:0]        diff;
   logic [63:0]        step;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rq_d    = rq_q;
      dsor_d  = dsor_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      quo_d   = quo_q;
      rem_d   = rem_q;

      // Remainder is always below the divisor, so the shifted partial fits in 33 bits.
      diff = rq_q[63:31] - {1'b0, dsor_q};
      step = diff[32] ? {rq_q[62:0], 1'b0} : {diff[31:0], rq_q[30:0], 1'b1};

      case (state_q)
         DIV_IDLE: begin
            if (start && !flush) begin
               if (divisor == ZERO_32) begin
                  quo_d   = '1;
                  rem_d   = dividend;
                  state_d = DIV_DONE;
               end else begin
                  negq_d  = signed_op & (dividend[31] ^ divisor[31]);
                  negr_d  = signed_op & dividend[31];
                  rq_d    = {ZERO_32, neg_if(dividend, signed_op & dividend[31])};
                  dsor_d  = neg_if(divisor, signed_op & divisor[31]);
                  cnt_d   = '0;
                  state_d = DIV_BUSY;
               end
            end
         end
         DIV_BUSY: begin
            rq_d  = step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               quo_d   = neg_if(step[31:0], negq_q);
               rem_d   = neg_if(step[63:32], negr_q);
               state_d = DIV_DONE;
            end
         end
         DIV_DONE: state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase

      if (flush) state_d = DIV_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         rq_q    <= '0;
         dsor_q  <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rq_q    <= rq_d;
         dsor_q  <= dsor_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
      end
   end

   assign busy      = (state_q == DIV_BUSY);
   assign done      = (state_q == DIV_DONE);
   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/ex.sv
// RV32IM execute stage: single-cycle ALU and multiplier, iterative divider
// with a stall request to pipeline control.
module ex
   import ex_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ALU_OP_BUS-1:0]   aluop_i,
   input  logic [ALU_SEL_BUS-1:0]  alusel_i,
   input  logic [REG_BUS-1:0]      reg1_i,
   input  logic [REG_BUS-1:0]      reg2_i,
   input  logic [REG_ADDR_BUS-1:0] wd_i,
   input  logic                    wreg_i,
   input  logic                    flush_i,
   output logic [REG_ADDR_BUS-1:0] wd_o,
   output logic                    wreg_o,
   output logic [REG_BUS-1:0]      wdata_o,
   output logic                    stallreq_o
);

   logic [REG_BUS-1:0] logic_res, shift_res, arith_res, mul_res;
   logic [63:0]        mul_a, mul_b, prod;
   logic               div_start, div_signed, div_busy, div_done;
   logic [REG_BUS-1:0] div_quo, div_rem;

   always_comb begin
      logic_res = ZERO_32;
      case (aluop_i)
         OP_AND:  logic_res = reg1_i & reg2_i;
         OP_OR:   logic_res = reg1_i | reg2_i;
         OP_XOR:  logic_res = reg1_i ^ reg2_i;
         default: logic_res = ZERO_32;
      endcase
   end

   always_comb begin
      shift_res = ZERO_32;
      case (aluop_i)
         OP_SLL:  shift_res = reg1_i << reg2_i[4:0];
         OP_SRL:  shift_res = reg1_i >> reg2_i[4:0];
         OP_SRA:  shift_res = $unsigned($signed(reg1_i) >>> reg2_i[4:0]);
         default: shift_res = ZERO_32;
      endcase
   end

   // AUIPC expects the PC on reg1_i; JAL produces PC+4 as the link value.
   always_comb begin
      arith_res = ZERO_32;
      case (aluop_i)
         OP_ADD, OP_AUIPC: arith_res = reg1_i + reg2_i;
         OP_SUB:   arith_res = reg1_i - reg2_i;
         OP_SLT:   arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
         OP_SLTU:  arith_res = {31'd0, reg1_i < reg2_i};
         OP_LUI:   arith_res = reg2_i;
         OP_JAL:   arith_res = reg1_i + 32'd4;
         default:  arith_res = ZERO_32;
      endcase
   end

   // Extending to 64 bits and keeping the low 64 of the product gives the
   // exact 64-bit result for every signedness combination.
   always_comb begin
      mul_a = {{32{(aluop_i == OP_MULH || aluop_i == OP_MULHSU) & reg1_i[31]}}, reg1_i};
      mul_b = {{32{(aluop_i == OP_MULH) & reg2_i[31]}}, reg2_i};
      prod  = mul_a * mul_b;
      mul_res = (aluop_i == OP_MUL) ? prod[31:0] : prod[63:32];
   end

   assign div_start  = (alusel_i == SEL_DIV);
   assign div_signed = (aluop_i == OP_DIV) || (aluop_i == OP_REM);

   ex_div u_div (
      .clk       (clk),
      .rst_n     (rst),
      .start     (div_start),
      .signed_op (div_signed),
      .dividend  (reg1_i),
      .divisor   (reg2_i),
      .flush     (flush_i),
      .busy      (div_busy),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   assign stallreq_o = !flush_i && (div_busy || (div_start && !div_busy && !div_done));

   always_comb begin
      wdata_o = ZERO_32;
      case (alusel_i)
         SEL_LOGIC: wdata_o = logic_res;
         SEL_SHIFT: wdata_o = shift_res;
         SEL_ARITH: wdata_o = arith_res;
         SEL_MUL:   wdata_o = mul_res;
         SEL_DIV:   wdata_o = (aluop_i == OP_REM || aluop_i == OP_REMU) ? div_rem : div_quo;
         default:   wdata_o = ZERO_32;
      endcase
   end

   assign wd_o   = wd_i;
   assign wreg_o = wreg_i;

endmodule

// File: tb/tb_ex.sv
// Directed bench for the execute stage: vector table for single-cycle ops,
// hand sequences for divide latency, divide by zero, flush and reset.
module tb_ex;
   import ex_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i, reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i, flush_i;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic        stallreq_o;

   int n_pass = 0;
   int n_total = 0;

   ex dut (
      .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
      .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
      .flush_i(flush_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  sel;
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      alusel_i = sel;
      aluop_i  = op;
      reg1_i   = a;
      reg2_i   = b;
   endtask

   // Issue a divide right after an edge, count stalled cycles, check result in DONE.
   task automatic run_div(input string name, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_stall);
      int n;
      n = 0;
      @(posedge clk); #1;
      drive(SEL_DIV, op, a, b);
      #1;
      while (stallreq_o && n < 100) begin
         n++;
         @(posedge clk); #2;
      end
      check({name, "_stall_cycles"}, n, exp_stall);
      check(name, wdata_o, exp);
   endtask

   initial begin
      vecs[0]  = '{SEL_ARITH, OP_ADD,    32'h7FFFFFFF, 32'h00000001, 32'h80000000};
      vecs[1]  = '{SEL_ARITH, OP_SUB,    32'h00000000, 32'h00000001, 32'hFFFFFFFF};
      vecs[2]  = '{SEL_ARITH, OP_SLT,    32'hFFFFFFFF, 32'h00000001, 32'h00000001};
      vecs[3]  = '{SEL_ARITH, OP_SLTU,   32'hFFFFFFFF, 32'h00000001, 32'h00000000};
      vecs[4]  = '{SEL_LOGIC, OP_AND,    32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
      vecs[5]  = '{SEL_LOGIC, OP_OR,     32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0};
      vecs[6]  = '{SEL_LOGIC, OP_XOR,    32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00};
      vecs[7]  = '{SEL_SHIFT, OP_SLL,    32'h00000001, 32'h0000003F, 32'h80000000};
      vecs[8]  = '{SEL_SHIFT, OP_SRL,    32'h80000000, 32'h00000004, 32'h08000000};
      vecs[9]  = '{SEL_SHIFT, OP_SRA,    32'h80000000, 32'h00000004, 32'hF8000000};
      vecs[10] = '{SEL_ARITH, OP_LUI,    32'hDEADBEEF, 32'h12345000, 32'h12345000};
      vecs[11] = '{SEL_ARITH, OP_AUIPC,  32'h00001000, 32'h00002000, 32'h00003000};
      vecs[12] = '{SEL_ARITH, OP_JAL,    32'h00001000, 32'h00000000, 32'h00001004};
      vecs[13] = '{SEL_MUL,   OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
      vecs[14] = '{SEL_MUL,   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      vecs[15] = '{SEL_MUL,   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vecs[16] = '{SEL_MUL,   OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[17] = '{SEL_MUL,   OP_MUL,    32'h00010000, 32'h00010000, 32'h00000000};
      vecs[18] = '{SEL_MUL,   OP_MULHU,  32'h00010000, 32'h00010000, 32'h00000001};
      vecs[19] = '{SEL_NOP,   OP_NOP,    32'h00000001, 32'h00000002, 32'h00000000};

      rst = 1'b0;
      flush_i = 1'b0;
      wd_i = '0;
      wreg_i = 1'b0;
      drive(SEL_NOP, OP_NOP, '0, '0);
      #2;
      check("reset_wdata", wdata_o, 32'h0);
      check("reset_stall", {31'd0, stallreq_o}, 32'h0);
      check("reset_wd_wreg", {26'd0, wreg_o, wd_o}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         drive(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b);
         wd_i = 5'(i + 1);
         wreg_i = i[0];
         #1;
         check($sformatf("vec%0d_wdata", i), wdata_o, vecs[i].exp);
         check($sformatf("vec%0d_stall", i), {31'd0, stallreq_o}, 32'h0);
         check($sformatf("vec%0d_pass", i), {26'd0, wreg_o, wd_o}, {26'd0, i[0], 5'(i + 1)});
      end

      // Back-to-back divides: each starts the cycle after the previous DONE.
      run_div("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
      run_div("rem_m7_2",   OP_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
      run_div("divu_5_0",   OP_DIVU, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1);
      run_div("remu_5_0",   OP_REMU, 32'h00000005, 32'h00000000, 32'h00000005, 1);
      run_div("div_ovf",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
      run_div("rem_ovf",    OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
      run_div("divu_big",   OP_DIVU, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 33);
      run_div("remu_big",   OP_REMU, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 33);
      run_div("rem_7_m2",   OP_REM,  32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33);

      // Flush at BUSY step 10.
      @(posedge clk); #1;
      drive(SEL_DIV, OP_DIVU, 32'd1000, 32'd3);
      for (int i = 0; i < 11; i++) @(posedge clk);
      #1;
      check("flush_pre_stall", {31'd0, stallreq_o}, 32'h1);
      flush_i = 1'b1;
      #1;
      check("flush_stall_same_cycle", {31'd0, stallreq_o}, 32'h0);
      @(posedge clk); #1;
      flush_i = 1'b0;
      drive(SEL_ARITH, OP_ADD, 32'd5, 32'd6);
      #1;
      check("post_flush_add", wdata_o, 32'd11);
      check("post_flush_stall", {31'd0, stallreq_o}, 32'h0);
      run_div("post_flush_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

      // Reset at BUSY step 20; ID/EX is in reset alongside.
      @(posedge clk); #1;
      drive(SEL_DIV, OP_DIV, 32'd12345, 32'd17);
      for (int i = 0; i < 21; i++) @(posedge clk);
      #1;
      check("rst_pre_stall", {31'd0, stallreq_o}, 32'h1);
      rst = 1'b0;
      drive(SEL_NOP, OP_NOP, '0, '0);
      wd_i = '0;
      wreg_i = 1'b0;
      #1;
      check("rst_stall", {31'd0, stallreq_o}, 32'h0);
      check("rst_wdata", wdata_o, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      run_div("post_rst_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
      run_div("post_rst_remu", OP_REMU, 32'd100, 32'd7, 32'd2, 33);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
